transpose_rd_rsp: RTL and testbench

Read-response sequencer for the Transpose engine. It snoops each read command accepted by the Transpose read-DMA and queues its burst length. It then consumes the returning MCIF read-data beats and tags every beat with its channel-group and pixel (w) index. The tagged beats go downstream to the transpose buffer write port, and the block pulses done after the final beat of the tensor.

---
 rtl/transpose_rd_rsp_pkg.sv | 27 ++
 rtl/trans_len_fifo.sv | 67 ++++++
 rtl/transpose_rd_rsp.sv | 233 +++++++++++++++++++++++
 tb/tb_transpose_rd_rsp.sv | 345 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/transpose_rd_rsp_pkg.sv
// Shared types and constants for the Transpose read-response sequencer.
package transpose_rd_rsp_pkg;

  localparam int TOUT               = 16;
  localparam int MAX_DAT_DW         = 32;
  localparam int LOG2_AXI_BURST_LEN = 4;
  localparam int LOG2_CH            = 10;
  localparam int LOG2_TOUT          = 4;
  localparam int LOG2_W             = 10;

  localparam int DAT_W_DFLT       = TOUT * MAX_DAT_DW;
  localparam int LEN_W_DFLT       = LOG2_AXI_BURST_LEN;
  localparam int CH_W_DFLT        = LOG2_CH - LOG2_TOUT;
  localparam int W_W_DFLT         = LOG2_W;
  localparam int LFIFO_DEPTH_DFLT = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIN  = 2'd2
  } trans_rsp_state_e;

  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/trans_len_fifo.sv
// Synchronous FIFO with registered count; a push at full is taken when a pop frees the slot.
// Latency: head valid the cycle after push. Backpressure: full/empty flags, caller gates push/pop.
// Depth must be a power of two.
module trans_len_fifo #(
  parameter int W     = 4,
  parameter int DEPTH = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] push_dat,
  input  logic         pop,
  output logic [W-1:0] head,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [W-1:0]  mem_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          do_push, do_pop;

  assign full  = (count_q == (AW+1)'(DEPTH));
  assign empty = (count_q == '0);
  assign head  = mem_q[rd_ptr_q];

  always_comb begin
    do_pop   = pop & ~empty;
    do_push  = push & (~full | do_pop);
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = push_dat;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/transpose_rd_rsp.sv
// Tags MCIF read beats with channel-group / pixel index using snooped burst lengths; done after last beat.
// Latency: 1 cycle accept-to-wr_vld, 1 beat/cycle. Backpressure: wr_rdy stalls the output register and rsp_rdy.
// TRANS_RSP_PERF_EN adds saturating perf_beats / perf_stall_in / perf_stall_out counters.
module transpose_rd_rsp
  import transpose_rd_rsp_pkg::*;
#(
  parameter int DAT_W       = DAT_W_DFLT,
  parameter int LEN_W       = LEN_W_DFLT,
  parameter int CH_W        = CH_W_DFLT,
  parameter int W_W         = W_W_DFLT,
  parameter int LFIFO_DEPTH = LFIFO_DEPTH_DFLT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CH_W-1:0]  CH_in_div_Tout,
  input  logic [W_W-1:0]   w_in,
  input  logic             cmd_snoop_vld,
  input  logic [LEN_W-1:0] cmd_snoop_len,
  output logic             cmd_snoop_rdy,
  input  logic             rsp_vld,
  output logic             rsp_rdy,
  input  logic [DAT_W-1:0] rsp_pd,
  output logic             wr_vld,
  input  logic             wr_rdy,
  output logic [DAT_W-1:0] wr_data,
  output logic [CH_W-1:0]  wr_ch,
  output logic [W_W-1:0]   wr_w,
  output logic             wr_last,
  output logic             done,
`ifdef TRANS_RSP_PERF_EN
  output logic [31:0]      perf_beats,
  output logic [31:0]      perf_stall_in,
  output logic [31:0]      perf_stall_out,
`endif
  output logic             err_underflow
);

  trans_rsp_state_e state_q, state_d;

  logic [CH_W-1:0]  ch_cfg_q, ch_cfg_d;
  logic [W_W-1:0]   w_cfg_q, w_cfg_d;
  logic [LEN_W-1:0] beat_cnt_q, beat_cnt_d;
  logic [CH_W-1:0]  ch_cnt_q, ch_cnt_d;
  logic [W_W-1:0]   w_blk_q, w_blk_d;
  logic             err_q, err_d;

  logic             wr_vld_q, wr_vld_d;
  logic [DAT_W-1:0] wr_data_q, wr_data_d;
  logic [CH_W-1:0]  wr_ch_q, wr_ch_d;
  logic [W_W-1:0]   wr_w_q, wr_w_d;
  logic             wr_last_q, wr_last_d;

  logic             is_run, start_acc, fin_exit, wr_hs;
  logic             fifo_full, fifo_empty, push, pop, accept;
  logic [LEN_W-1:0] head_len;
  logic             cmd_end, ch_end, tag_last;
  logic [W_W-1:0]   tag_w;

  trans_len_fifo #(
    .W     (LEN_W),
    .DEPTH (LFIFO_DEPTH)
  ) u_len_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .push_dat (cmd_snoop_len),
    .pop      (pop),
    .head     (head_len),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start) state_d = ST_RUN;
      ST_RUN:  if (wr_hs && wr_last_q) state_d = ST_FIN;
      ST_FIN:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    is_run    = (state_q == ST_RUN);
    done      = (state_q == ST_FIN);
    fin_exit  = (state_q == ST_FIN);
    start_acc = (state_q == ST_IDLE) && start;
  end

  assign cmd_snoop_rdy = ~fifo_full & ~rst;
  assign push          = cmd_snoop_vld & cmd_snoop_rdy;
  assign rsp_rdy       = is_run & ~fifo_empty & (~wr_vld_q | wr_rdy);
  assign accept        = rsp_vld & rsp_rdy;
  assign wr_hs         = wr_vld_q & wr_rdy;

  // Pixel index: w_blk selects the burst-sized window, beat_cnt the offset inside it.
  always_comb begin
    cmd_end  = (beat_cnt_q == head_len);
    ch_end   = (ch_cnt_q == ch_cfg_q - CH_W'(1));
    tag_w    = W_W'({w_blk_q, {LEN_W{1'b0}}}) + W_W'(beat_cnt_q);
    tag_last = ch_end && (tag_w == w_cfg_q - W_W'(1)) && cmd_end;
    pop      = accept & cmd_end;
  end

  always_comb begin
    ch_cfg_d   = ch_cfg_q;
    w_cfg_d    = w_cfg_q;
    beat_cnt_d = beat_cnt_q;
    ch_cnt_d   = ch_cnt_q;
    w_blk_d    = w_blk_q;
    err_d      = err_q | (is_run & rsp_vld & fifo_empty);
    if (start_acc) begin
      ch_cfg_d = CH_in_div_Tout;
      w_cfg_d  = w_in;
    end
    if (start_acc || fin_exit) begin
      beat_cnt_d = '0;
      ch_cnt_d   = '0;
      w_blk_d    = '0;
    end else if (accept) begin
      if (cmd_end) begin
        beat_cnt_d = '0;
        if (ch_end) begin
          ch_cnt_d = '0;
          w_blk_d  = w_blk_q + 1'b1;
        end else begin
          ch_cnt_d = ch_cnt_q + 1'b1;
        end
      end else begin
        beat_cnt_d = beat_cnt_q + 1'b1;
      end
    end
  end

  always_comb begin
    wr_vld_d  = wr_vld_q;
    wr_data_d = wr_data_q;
    wr_ch_d   = wr_ch_q;
    wr_w_d    = wr_w_q;
    wr_last_d = wr_last_q;
    if (accept) begin
      wr_vld_d  = 1'b1;
      wr_data_d = rsp_pd;
      wr_ch_d   = ch_cnt_q;
      wr_w_d    = tag_w;
      wr_last_d = tag_last;
    end else if (wr_rdy) begin
      wr_vld_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ch_cfg_q   <= '0;
      w_cfg_q    <= '0;
      beat_cnt_q <= '0;
      ch_cnt_q   <= '0;
      w_blk_q    <= '0;
      err_q      <= 1'b0;
      wr_vld_q   <= 1'b0;
      wr_data_q  <= '0;
      wr_ch_q    <= '0;
      wr_w_q     <= '0;
      wr_last_q  <= 1'b0;
    end else begin
      ch_cfg_q   <= ch_cfg_d;
      w_cfg_q    <= w_cfg_d;
      beat_cnt_q <= beat_cnt_d;
      ch_cnt_q   <= ch_cnt_d;
      w_blk_q    <= w_blk_d;
      err_q      <= err_d;
      wr_vld_q   <= wr_vld_d;
      wr_data_q  <= wr_data_d;
      wr_ch_q    <= wr_ch_d;
      wr_w_q     <= wr_w_d;
      wr_last_q  <= wr_last_d;
    end
  end

  assign wr_vld        = wr_vld_q;
  assign wr_data       = wr_data_q;
  assign wr_ch         = wr_ch_q;
  assign wr_w          = wr_w_q;
  assign wr_last       = wr_last_q;
  assign err_underflow = err_q;

`ifdef TRANS_RSP_PERF_EN
  logic [31:0] perf_beats_q, perf_beats_d;
  logic [31:0] perf_stall_in_q, perf_stall_in_d;
  logic [31:0] perf_stall_out_q, perf_stall_out_d;

  always_comb begin
    perf_beats_d     = perf_beats_q;
    perf_stall_in_d  = perf_stall_in_q;
    perf_stall_out_d = perf_stall_out_q;
    if (start_acc) begin
      perf_beats_d     = '0;
      perf_stall_in_d  = '0;
      perf_stall_out_d = '0;
    end else begin
      if (accept)              perf_beats_d     = sat_inc32(perf_beats_q);
      if (is_run && !rsp_vld)  perf_stall_in_d  = sat_inc32(perf_stall_in_q);
      if (wr_vld_q && !wr_rdy) perf_stall_out_d = sat_inc32(perf_stall_out_q);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_beats_q     <= '0;
      perf_stall_in_q  <= '0;
      perf_stall_out_q <= '0;
    end else begin
      perf_beats_q     <= perf_beats_d;
      perf_stall_in_q  <= perf_stall_in_d;
      perf_stall_out_q <= perf_stall_out_d;
    end
  end

  assign perf_beats     = perf_beats_q;
  assign perf_stall_in  = perf_stall_in_q;
  assign perf_stall_out = perf_stall_out_q;
`endif

endmodule

// File: tb/tb_transpose_rd_rsp.sv
// Directed + randomized bench for transpose_rd_rsp with a command-walking reference model.
module tb_transpose_rd_rsp;
  localparam int DAT_W = 512;
  localparam int LEN_W = 4;
  localparam int CH_W  = 6;
  localparam int W_W   = 10;
  localparam int CW    = 544;

  typedef struct packed {
    logic [DAT_W-1:0] d;
    logic [CH_W-1:0]  ch;
    logic [W_W-1:0]   w;
    logic             last;
  } beat_t;

  logic             clk = 1'b0;
  logic             rst, start;
  logic [CH_W-1:0]  CH_in_div_Tout;
  logic [W_W-1:0]   w_in;
  logic             cmd_snoop_vld, cmd_snoop_rdy;
  logic [LEN_W-1:0] cmd_snoop_len;
  logic             rsp_vld, rsp_rdy;
  logic [DAT_W-1:0] rsp_pd;
  logic             wr_vld, wr_rdy, wr_last, done, err_underflow;
  logic [DAT_W-1:0] wr_data;
  logic [CH_W-1:0]  wr_ch;
  logic [W_W-1:0]   wr_w;
`ifdef TRANS_RSP_PERF_EN
  logic [31:0]      perf_beats, perf_stall_in, perf_stall_out;
`endif

  transpose_rd_rsp dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .CH_in_div_Tout (CH_in_div_Tout),
    .w_in           (w_in),
    .cmd_snoop_vld  (cmd_snoop_vld),
    .cmd_snoop_len  (cmd_snoop_len),
    .cmd_snoop_rdy  (cmd_snoop_rdy),
    .rsp_vld        (rsp_vld),
    .rsp_rdy        (rsp_rdy),
    .rsp_pd         (rsp_pd),
    .wr_vld         (wr_vld),
    .wr_rdy         (wr_rdy),
    .wr_data        (wr_data),
    .wr_ch          (wr_ch),
    .wr_w           (wr_w),
    .wr_last        (wr_last),
    .done           (done),
`ifdef TRANS_RSP_PERF_EN
    .perf_beats     (perf_beats),
    .perf_stall_in  (perf_stall_in),
    .perf_stall_out (perf_stall_out),
`endif
    .err_underflow  (err_underflow)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int done_cnt = 0;
  int done_cyc = -1;
  int last_hs_cyc = -100;
  int rdy_mode = 0;
  beat_t obs_q[$];
  beat_t exp_q[$];
  logic [DAT_W-1:0] sent_q[$];
  logic  stall_prev = 1'b0;
  beat_t held, mon_cur;

  task automatic chk(input string tag, input logic [CW-1:0] o, input logic [CW-1:0] e);
    n_cmp++;
    assert (o === e) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin
    wr_rdy = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       wr_rdy = 1'b1;
        1:       wr_rdy = ~wr_rdy;
        default: wr_rdy = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Output monitor: collects handshakes, checks hold-during-stall and done pulses.
  always @(negedge clk) begin
    if (rst) begin
      stall_prev = 1'b0;
    end else begin
      mon_cur = {wr_data, wr_ch, wr_w, wr_last};
      if (stall_prev) begin
        chk("stall_vld", wr_vld, 1);
        chk("stall_hold", mon_cur, held);
      end
      if (wr_vld && wr_rdy) begin
        obs_q.push_back(mon_cur);
        if (wr_last) last_hs_cyc = cyc;
      end
      if (wr_vld && !wr_rdy) begin
        chk("rsp_rdy_stall", rsp_rdy, 0);
        held       = mon_cur;
        stall_prev = 1'b1;
      end else begin
        stall_prev = 1'b0;
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
    end
  end

  function automatic logic [DAT_W-1:0] rand_dat();
    logic [DAT_W-1:0] r;
    for (int i = 0; i < DAT_W/32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; start = 1'b0; cmd_snoop_vld = 1'b0; rsp_vld = 1'b0;
    tick();
    tick();
    @(negedge clk);
    chk("rst_ctl", {wr_vld, wr_last, done, err_underflow, rsp_rdy, cmd_snoop_rdy}, 0);
    chk("rst_tag", {wr_ch, wr_w}, 0);
    chk("rst_data", wr_data, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_snoop_rdy", cmd_snoop_rdy, 1);
    tick();
  endtask

  task automatic snoop(input int len);
    cmd_snoop_vld = 1'b1;
    cmd_snoop_len = LEN_W'(len);
    tick();
    cmd_snoop_vld = 1'b0;
  endtask

  task automatic pulse_start(input int ch, input int w);
    CH_in_div_Tout = CH_W'(ch);
    w_in = W_W'(w);
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send_beats(input int n, input int start_at);
    for (int i = 0; i < n; i++) begin
      logic [DAT_W-1:0] dat;
      int t;
      dat = rand_dat();
      rsp_vld = 1'b1;
      rsp_pd = dat;
      if (i == start_at) begin
        start = 1'b1;
        CH_in_div_Tout = CH_W'(1);
        w_in = W_W'(5);
      end
      t = 0;
      @(negedge clk);
      while (!rsp_rdy && t < 200) begin
        tick();
        @(negedge clk);
        t++;
      end
      if (!rsp_rdy) begin
        chk("accept_timeout", rsp_rdy, 1);
        break;
      end
      sent_q.push_back(dat);
      tick();
      start = 1'b0;
    end
    rsp_vld = 1'b0;
  endtask

  task automatic wait_done();
    int t;
    t = 0;
    while (done_cnt == 0 && t < 500) begin
      tick();
      t++;
    end
    repeat (4) tick();
    chk("done_count", done_cnt, 1);
    chk("done_timing", done_cyc, last_hs_cyc + 1);
  endtask

  // Reference: command k covers channel group k%ch and w-window k/ch; beats run 0..len.
  task automatic check_tensor(input int ch, input int w, input int lens[$]);
    int idx;
    beat_t b;
    exp_q.delete();
    idx = 0;
    for (int k = 0; k < lens.size(); k++) begin
      for (int j = 0; j <= lens[k]; j++) begin
        int wv;
        wv     = ((k / ch) * (1 << LEN_W) + j) % (1 << W_W);
        b.d    = (idx < sent_q.size()) ? sent_q[idx] : '0;
        b.ch   = CH_W'(k % ch);
        b.w    = W_W'(wv);
        b.last = (k % ch == ch - 1) && (wv == w - 1) && (j == lens[k]);
        exp_q.push_back(b);
        idx++;
      end
    end
    chk("beat_count", obs_q.size(), exp_q.size());
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++)
      chk($sformatf("beat%0d", i), obs_q[i], exp_q[i]);
  endtask

  task automatic run_tensor(input int ch, input int w, input int lens[$], input int mode,
                            input int start_at);
    int total;
    rdy_mode = mode;
    obs_q.delete();
    sent_q.delete();
    done_cnt = 0;
    total = 0;
    foreach (lens[i]) begin
      snoop(lens[i]);
      total += lens[i] + 1;
    end
    pulse_start(ch, w);
    send_beats(total, start_at);
    wait_done();
    check_tensor(ch, w, lens);
    rdy_mode = 0;
  endtask

  initial begin
    int lq[$];
    logic [DAT_W-1:0] d0;
    rst = 1'b1; start = 1'b0; cmd_snoop_vld = 1'b0; cmd_snoop_len = '0;
    rsp_vld = 1'b0; rsp_pd = '0; CH_in_div_Tout = '0; w_in = '0;
    do_reset();

    // Basic tensor, then with toggling wr_rdy.
    lq = {15, 15, 3, 3};
    run_tensor(2, 20, lq, 0, -1);
    run_tensor(2, 20, lq, 1, -1);

    // Length FIFO fill, blocked push at full, push+pop keeping the count.
    obs_q.delete(); sent_q.delete(); done_cnt = 0;
    for (int i = 0; i < 8; i++) snoop(0);
    @(negedge clk);
    chk("fifo_full_rdy", cmd_snoop_rdy, 0);
    pulse_start(1, 145);
    d0 = rand_dat();
    rsp_vld = 1'b1; rsp_pd = d0; cmd_snoop_vld = 1'b1; cmd_snoop_len = '0;
    @(negedge clk);
    chk("full_rsp_rdy", rsp_rdy, 1);
    chk("full_pop_cycle_rdy", cmd_snoop_rdy, 0);
    sent_q.push_back(d0);
    tick();
    d0 = rand_dat();
    rsp_pd = d0;
    @(negedge clk);
    chk("after_pop_rdy", cmd_snoop_rdy, 1);
    chk("pushpop_rsp_rdy", rsp_rdy, 1);
    sent_q.push_back(d0);
    tick();
    rsp_vld = 1'b0;
    @(negedge clk);
    chk("pushpop_keep_rdy", cmd_snoop_rdy, 1);
    tick();
    cmd_snoop_vld = 1'b0;
    @(negedge clk);
    chk("refill_full_rdy", cmd_snoop_rdy, 0);
    tick();
    send_beats(8, -1);
    wait_done();
    lq = {0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    check_tensor(1, 145, lq);

    // Underflow: beat in RUN with no snooped command.
    pulse_start(1, 1);
    rsp_vld = 1'b1; rsp_pd = rand_dat();
    @(negedge clk);
    chk("underflow_rdy", rsp_rdy, 0);
    tick();
    @(negedge clk);
    chk("underflow_set", err_underflow, 1);
    rsp_vld = 1'b0;
    repeat (3) tick();
    @(negedge clk);
    chk("underflow_sticky", err_underflow, 1);
    do_reset();

    // Abort mid-tensor, then a minimal fresh tensor.
    done_cnt = 0;
    lq = {15, 15, 3, 3};
    foreach (lq[i]) snoop(lq[i]);
    pulse_start(2, 20);
    send_beats(10, -1);
    do_reset();
    repeat (3) tick();
    chk("abort_no_done", done_cnt, 0);
    lq = {0};
    run_tensor(1, 1, lq, 0, -1);

    // Start pulsed during RUN with a different config must be ignored.
    lq = {15, 15, 3, 3};
    run_tensor(2, 20, lq, 0, 20);

    // Randomized configurations covering whole tensors.
    for (int r = 0; r < 4; r++) begin
      int ch, w;
      ch = $urandom_range(1, 2);
      w  = $urandom_range(1, 64);
      lq.delete();
      for (int wb = 0; wb * 16 < w; wb++) begin
        int n;
        n = (w - wb * 16 < 16) ? (w - wb * 16) : 16;
        for (int c = 0; c < ch; c++) lq.push_back(n - 1);
      end
      run_tensor(ch, w, lq, 2, -1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
